// File: rtl/stack_mask_sequencer_pkg.sv
// Shared types and register-slot mask constants for the stack mask sequencer.
package stack_mask_sequencer_pkg;

  localparam int unsigned STACK_MASK_W = 16;

  // One bit per register-file slot; bit order is also the push order.
  localparam logic [STACK_MASK_W-1:0] STACK_AW   = 16'h0001;
  localparam logic [STACK_MASK_W-1:0] STACK_CW   = 16'h0002;
  localparam logic [STACK_MASK_W-1:0] STACK_DW   = 16'h0004;
  localparam logic [STACK_MASK_W-1:0] STACK_BW   = 16'h0008;
  localparam logic [STACK_MASK_W-1:0] STACK_SP   = 16'h0010;
  localparam logic [STACK_MASK_W-1:0] STACK_BP   = 16'h0020;
  localparam logic [STACK_MASK_W-1:0] STACK_IX   = 16'h0040;
  localparam logic [STACK_MASK_W-1:0] STACK_IY   = 16'h0080;
  localparam logic [STACK_MASK_W-1:0] STACK_DS1  = 16'h0100;
  localparam logic [STACK_MASK_W-1:0] STACK_PS   = 16'h0200;
  localparam logic [STACK_MASK_W-1:0] STACK_SS   = 16'h0400;
  localparam logic [STACK_MASK_W-1:0] STACK_DS0  = 16'h0800;
  localparam logic [STACK_MASK_W-1:0] STACK_PSW  = 16'h1000;
  localparam logic [STACK_MASK_W-1:0] STACK_PC   = 16'h2000;
  localparam logic [STACK_MASK_W-1:0] STACK_ALLR = 16'h00FF;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_PUSH,
    SEQ_POP,
    SEQ_FIN
  } seq_state_e;

  // Push/pop lists as carried out of the pre-decoder.
  typedef struct packed {
    logic [STACK_MASK_W-1:0] push;
    logic [STACK_MASK_W-1:0] pop;
  } stack_seq_req_t;

endpackage

// File: rtl/stack_mask_sequencer_scan.sv
// Combinational find-first-set over a mask, lowest-first or highest-first.
module stack_mask_scan
  import stack_mask_sequencer_pkg::*;
#(
  parameter int unsigned MASK_W = 16,
  parameter int unsigned IDX_W  = $clog2(MASK_W)
) (
  input  logic [MASK_W-1:0] mask,
  input  logic              dir_high,
  output logic [IDX_W-1:0]  idx,
  output logic              valid
);

  // The last match written wins, so the loop direction picks the end searched.
  always_comb begin
    idx   = '0;
    valid = |mask;
    if (dir_high) begin
      for (int i = 0; i < int'(MASK_W); i++) begin
        if (mask[i]) idx = IDX_W'(i);
      end
    end else begin
      for (int i = int'(MASK_W) - 1; i >= 0; i--) begin
        if (mask[i]) idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/stack_mask_sequencer.sv
// Walks push then pop register masks, issuing stack bus cycles at SS:SP.
// Optional macro STACK_WRAP_FAULT_EN adds wrap_fault and aborts on SP wrap.
module stack_mask_sequencer
  import stack_mask_sequencer_pkg::*;
#(
  parameter int unsigned MASK_W    = 16,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 20,
  parameter int unsigned SP_INDEX  = 4,
  parameter int unsigned SEG_SHIFT = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [MASK_W-1:0]         push_mask,
  input  logic [MASK_W-1:0]         pop_mask,
  input  logic [15:0]               sp_in,
  input  logic [15:0]               ss_in,
  output logic                      busy,
  output logic                      done,
  output logic [15:0]               sp_out,
  output logic [$clog2(MASK_W)-1:0] reg_rd_idx,
  input  logic [DATA_W-1:0]         reg_rd_data,
  output logic                      reg_wr_en,
  output logic [$clog2(MASK_W)-1:0] reg_wr_idx,
  output logic [DATA_W-1:0]         reg_wr_data,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic                      mem_ack,
  input  logic [DATA_W-1:0]         mem_rdata
`ifdef STACK_WRAP_FAULT_EN
  ,
  output logic                      wrap_fault
`endif
);

  localparam int unsigned IDX_W = $clog2(MASK_W);
  localparam logic [15:0] STEP = 16'(DATA_W / 8);
  localparam logic [IDX_W-1:0] SP_IDX = IDX_W'(SP_INDEX);

  seq_state_e         state;
  logic [MASK_W-1:0]  push_rem, pop_rem;
  logic [15:0]        sp, ss, sp_start;
  logic [IDX_W-1:0]   cur_idx;
  logic               wr_en_q;
  logic [IDX_W-1:0]   wr_idx_q;
  logic [DATA_W-1:0]  wr_data_q;

  logic               idle, advance, pop_wr_c;
  logic [MASK_W-1:0]  src_push, src_pop;
  logic [15:0]        src_sp, src_ss, src_sp0, push_sp, pop_sp;
  logic [ADDR_W-1:0]  seg_base;
  logic [IDX_W-1:0]   push_idx, pop_idx;
  logic               push_vld, pop_vld, push_fault, pop_fault, abort_c;

  // In IDLE the next step is taken straight from the start inputs.
  always_comb begin
    idle     = (state == SEQ_IDLE);
    src_push = idle ? push_mask : push_rem;
    src_pop  = idle ? pop_mask  : pop_rem;
    src_sp   = idle ? sp_in     : sp;
    src_ss   = idle ? ss_in     : ss;
    src_sp0  = idle ? sp_in     : sp_start;
    advance  = idle ? start
                    : ((state == SEQ_PUSH || state == SEQ_POP) && mem_req && mem_ack);
    push_sp  = src_sp - STEP;
    pop_sp   = src_sp + STEP;
    seg_base = ADDR_W'(ADDR_W'(src_ss) << SEG_SHIFT);
  end

  stack_mask_scan #(.MASK_W(MASK_W), .IDX_W(IDX_W)) u_push_scan (
    .mask     (src_push),
    .dir_high (1'b0),
    .idx      (push_idx),
    .valid    (push_vld)
  );

  stack_mask_scan #(.MASK_W(MASK_W), .IDX_W(IDX_W)) u_pop_scan (
    .mask     (src_pop),
    .dir_high (1'b1),
    .idx      (pop_idx),
    .valid    (pop_vld)
  );

`ifdef STACK_WRAP_FAULT_EN
  logic fault_q;
  assign push_fault = (src_sp < STEP);
  assign pop_fault  = (src_sp > (16'hFFFF - STEP));
  assign wrap_fault = fault_q;
`else
  assign push_fault = 1'b0;
  assign pop_fault  = 1'b0;
`endif

  assign abort_c = push_vld ? push_fault : (pop_vld && pop_fault);

  // Read index must be live at the issuing edge so push data can be registered.
  assign reg_rd_idx = ((idle && start) || state == SEQ_PUSH) ? push_idx : '0;

  // Pop data is written in the ack cycle, leaving the done cycle free for SP.
  assign pop_wr_c    = reset_n && (state == SEQ_POP) && mem_req && mem_ack && (cur_idx != SP_IDX);
  assign reg_wr_en   = pop_wr_c || wr_en_q;
  assign reg_wr_idx  = pop_wr_c ? cur_idx : wr_idx_q;
  assign reg_wr_data = pop_wr_c ? mem_rdata : wr_data_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= SEQ_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wr_en_q   <= 1'b0;
      wr_idx_q  <= '0;
      wr_data_q <= '0;
      sp_out    <= '0;
      push_rem  <= '0;
      pop_rem   <= '0;
      sp        <= '0;
      ss        <= '0;
      sp_start  <= '0;
      cur_idx   <= '0;
`ifdef STACK_WRAP_FAULT_EN
      fault_q   <= 1'b0;
`endif
    end else begin
      done    <= 1'b0;
      wr_en_q <= 1'b0;
`ifdef STACK_WRAP_FAULT_EN
      fault_q <= 1'b0;
`endif
      if (state == SEQ_FIN) begin
        state <= SEQ_IDLE;
        busy  <= 1'b0;
      end else if (advance) begin
        if (idle) begin
          busy     <= 1'b1;
          ss       <= ss_in;
          sp_start <= sp_in;
        end
        if (push_vld && !push_fault) begin
          state     <= SEQ_PUSH;
          push_rem  <= src_push & ~(MASK_W'(1) << push_idx);
          pop_rem   <= src_pop;
          sp        <= push_sp;
          mem_req   <= 1'b1;
          mem_we    <= 1'b1;
          mem_addr  <= seg_base + ADDR_W'(push_sp);
          mem_wdata <= (push_idx == SP_IDX) ? DATA_W'(src_sp0) : reg_rd_data;
        end else if (!push_vld && pop_vld && !pop_fault) begin
          state    <= SEQ_POP;
          push_rem <= '0;
          pop_rem  <= src_pop & ~(MASK_W'(1) << pop_idx);
          sp       <= pop_sp;
          cur_idx  <= pop_idx;
          mem_req  <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= seg_base + ADDR_W'(src_sp);
        end else begin
          // Sequence complete or aborted; SP writeback only on clean completion.
          state   <= SEQ_FIN;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          done    <= 1'b1;
          sp_out  <= src_sp;
          if (!abort_c) begin
            wr_en_q   <= 1'b1;
            wr_idx_q  <= SP_IDX;
            wr_data_q <= DATA_W'(src_sp);
          end
`ifdef STACK_WRAP_FAULT_EN
          fault_q <= abort_c;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_stack_mask_sequencer.sv
// Directed self-checking bench for stack_mask_sequencer.
module tb_stack_mask_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] push_mask = '0, pop_mask = '0, sp_in = '0, ss_in = '0;
  logic        busy, done, reg_wr_en, mem_req, mem_we;
  logic [15:0] sp_out, reg_rd_data, reg_wr_data, mem_wdata;
  logic [3:0]  reg_rd_idx, reg_wr_idx;
  logic [19:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;
`ifdef STACK_WRAP_FAULT_EN
  logic        wrap_fault;
`endif

  logic [15:0] rf [16];
  assign reg_rd_data = rf[reg_rd_idx];

  stack_mask_sequencer #(
    .MASK_W(16), .DATA_W(16), .ADDR_W(20), .SP_INDEX(4), .SEG_SHIFT(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .push_mask(push_mask), .pop_mask(pop_mask), .sp_in(sp_in), .ss_in(ss_in),
    .busy(busy), .done(done), .sp_out(sp_out),
    .reg_rd_idx(reg_rd_idx), .reg_rd_data(reg_rd_data),
    .reg_wr_en(reg_wr_en), .reg_wr_idx(reg_wr_idx), .reg_wr_data(reg_wr_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
`ifdef STACK_WRAP_FAULT_EN
    , .wrap_fault(wrap_fault)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0;
  int wait_cfg = 0, wcnt = 0;
  logic force_ack = 1'b0;
  int done_cnt = 0, done_cyc = 0, stab_err = 0;
  logic [15:0] done_sp = '0;
  logic        done_wf = 1'b0;
  logic        prev_wait = 1'b0, p_we = 1'b0;
  logic [19:0] p_addr = '0;
  logic [15:0] p_wd = '0;

  logic [31:0] bus_addr[$];
  logic        bus_we[$];
  logic [15:0] bus_wd[$];
  logic [3:0]  rw_idx[$];
  logic [15:0] rw_dat[$];
  logic [15:0] rq[$];
  logic [31:0] e_addr[$];
  logic        e_we[$];
  logic [15:0] e_wd[$];
  logic [3:0]  e_idx[$];
  logic [15:0] e_dat[$];

  always @(posedge clk) cyc++;

  // Bus slave: ack after wait_cfg idle cycles, pop data from rq.
  always @(negedge clk) begin
    if (mem_req) begin
      if (wcnt >= wait_cfg) begin
        mem_ack = 1'b1;
        wcnt = 0;
        if (!mem_we) begin
          if (rq.size() > 0) mem_rdata = rq.pop_front();
          else mem_rdata = 16'hDEAD;
        end
      end else begin
        mem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      mem_ack = force_ack;
      wcnt = 0;
    end
  end

  // Monitor: logs accepted bus cycles, register writes, done and hold stability.
  always @(negedge clk) begin
    #2;
    if (reset_n && mem_req && mem_ack) begin
      bus_addr.push_back(32'(mem_addr));
      bus_we.push_back(mem_we);
      bus_wd.push_back(mem_wdata);
    end
    if (reset_n && reg_wr_en) begin
      rw_idx.push_back(reg_wr_idx);
      rw_dat.push_back(reg_wr_data);
    end
    if (reset_n && done) begin
      done_cnt++;
      done_cyc = cyc;
      done_sp = sp_out;
`ifdef STACK_WRAP_FAULT_EN
      done_wf = wrap_fault;
`endif
    end
    if (reset_n && prev_wait && (mem_addr !== p_addr || mem_we !== p_we || mem_wdata !== p_wd))
      stab_err++;
    prev_wait = reset_n && mem_req && !mem_ack;
    p_addr = mem_addr;
    p_we = mem_we;
    p_wd = mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    bus_addr.delete(); bus_we.delete(); bus_wd.delete();
    rw_idx.delete(); rw_dat.delete(); rq.delete();
    e_addr.delete(); e_we.delete(); e_wd.delete(); e_idx.delete(); e_dat.delete();
  endtask

  task automatic exp_bus(input logic we, input logic [31:0] a, input logic [15:0] d);
    e_we.push_back(we); e_addr.push_back(a); e_wd.push_back(d);
  endtask

  task automatic exp_reg(input logic [3:0] i, input logic [15:0] d);
    e_idx.push_back(i); e_dat.push_back(d);
  endtask

  task automatic check_logs(input string tag);
    chk({tag, "_bus_count"}, 32'(bus_addr.size()), 32'(e_addr.size()));
    if (bus_addr.size() == e_addr.size()) begin
      for (int k = 0; k < e_addr.size(); k++) begin
        chk($sformatf("%s_addr%0d", tag, k), bus_addr[k], e_addr[k]);
        chk($sformatf("%s_we%0d", tag, k), 32'(bus_we[k]), 32'(e_we[k]));
        if (e_we[k]) chk($sformatf("%s_wdata%0d", tag, k), 32'(bus_wd[k]), 32'(e_wd[k]));
      end
    end
    chk({tag, "_regwr_count"}, 32'(rw_idx.size()), 32'(e_idx.size()));
    if (rw_idx.size() == e_idx.size()) begin
      for (int k = 0; k < e_idx.size(); k++) begin
        chk($sformatf("%s_wridx%0d", tag, k), 32'(rw_idx[k]), 32'(e_idx[k]));
        chk($sformatf("%s_wrdata%0d", tag, k), 32'(rw_dat[k]), 32'(e_dat[k]));
      end
    end
  endtask

  task automatic launch(input logic [15:0] pm, input logic [15:0] qm, input logic [15:0] sp,
                        input logic [15:0] ss, input int wt, output int t0, output int base);
    @(negedge clk);
    wait_cfg = wt;
    push_mask = pm; pop_mask = qm; sp_in = sp; ss_in = ss; start = 1'b1;
    t0 = cyc;
    base = done_cnt;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, input string tag);
    int n = 0;
    while (done_cnt == base && n < 200) begin
      @(negedge clk);
      #3;
      n++;
    end
    chk({tag, "_done_seen"}, 32'(done_cnt != base), 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_reg_wr_en"}, 32'(reg_wr_en), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    chk({tag, "_reg_wr_idx"}, 32'(reg_wr_idx), 32'd0);
    chk({tag, "_reg_wr_data"}, 32'(reg_wr_data), 32'd0);
    chk({tag, "_reg_rd_idx"}, 32'(reg_rd_idx), 32'd0);
    chk({tag, "_sp_out"}, 32'(sp_out), 32'd0);
  endtask

  initial begin
    int t0, base;
    for (int i = 0; i < 16; i++) rf[i] = 16'(16'hA000 + i * 16'h0101);

    // Reset state
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_reset_state("rst0");

    // 1: push AW, CW
    clear_logs();
    exp_bus(1'b1, 32'h200FE, 16'hA000);
    exp_bus(1'b1, 32'h200FC, 16'hA101);
    exp_reg(4'd4, 16'h00FC);
    launch(16'h0003, 16'h0000, 16'h0100, 16'h2000, 0, t0, base);
    #1;
    chk("t1_busy_t1", 32'(busy), 32'd1);
    chk("t1_req_t1", 32'(mem_req), 32'd1);
    chk("t1_addr_t1", 32'(mem_addr), 32'h200FE);
    wait_done(base, "t1");
    chk("t1_done_cycle", 32'(done_cyc - t0), 32'd3);
    chk("t1_sp_out", 32'(done_sp), 32'h00FC);
    @(negedge clk); #3;
    chk("t1_idle_after", 32'(busy), 32'd0);
    check_logs("t1");

    // 2: pop CW then AW
    clear_logs();
    rq.push_back(16'h1111); rq.push_back(16'h2222);
    exp_bus(1'b0, 32'h200FC, 16'h0);
    exp_bus(1'b0, 32'h200FE, 16'h0);
    exp_reg(4'd1, 16'h1111);
    exp_reg(4'd0, 16'h2222);
    exp_reg(4'd4, 16'h0100);
    launch(16'h0000, 16'h0003, 16'h00FC, 16'h2000, 0, t0, base);
    wait_done(base, "t2");
    chk("t2_done_cycle", 32'(done_cyc - t0), 32'd3);
    chk("t2_sp_out", 32'(done_sp), 32'h0100);
    check_logs("t2");

    // 3a: push all eight registers
    clear_logs();
    for (int i = 0; i < 8; i++)
      exp_bus(1'b1, 32'h20200 - 32'(2 * (i + 1)), (i == 4) ? 16'h0200 : rf[i]);
    exp_reg(4'd4, 16'h01F0);
    launch(16'h00FF, 16'h0000, 16'h0200, 16'h2000, 0, t0, base);
    wait_done(base, "t3a");
    chk("t3a_done_cycle", 32'(done_cyc - t0), 32'd9);
    chk("t3a_sp_out", 32'(done_sp), 32'h01F0);
    check_logs("t3a");

    // 3b: pop all eight, SP slot discarded
    clear_logs();
    for (int k = 0; k < 8; k++) begin
      rq.push_back(16'(16'h3000 + k));
      exp_bus(1'b0, 32'h201F0 + 32'(2 * k), 16'h0);
      if (k != 3) exp_reg(4'(7 - k), 16'(16'h3000 + k));
    end
    exp_reg(4'd4, 16'h0200);
    launch(16'h0000, 16'h00FF, 16'h01F0, 16'h2000, 0, t0, base);
    wait_done(base, "t3b");
    chk("t3b_done_cycle", 32'(done_cyc - t0), 32'd9);
    chk("t3b_sp_out", 32'(done_sp), 32'h0200);
    check_logs("t3b");

    // 4: push PC then pop AW with three wait cycles per request
    clear_logs();
    stab_err = 0;
    rq.push_back(16'h4444);
    exp_bus(1'b1, 32'h200FE, 16'hAD0D);
    exp_bus(1'b0, 32'h200FE, 16'h0);
    exp_reg(4'd0, 16'h4444);
    exp_reg(4'd4, 16'h0100);
    launch(16'h2000, 16'h0001, 16'h0100, 16'h2000, 3, t0, base);
    wait_done(base, "t4");
    chk("t4_done_cycle", 32'(done_cyc - t0), 32'd9);
    chk("t4_sp_out", 32'(done_sp), 32'h0100);
    chk("t4_hold_stable", 32'(stab_err), 32'd0);
    check_logs("t4");

    // 5a: both masks zero
    clear_logs();
    exp_reg(4'd4, 16'h1234);
    launch(16'h0000, 16'h0000, 16'h1234, 16'h2000, 0, t0, base);
    wait_done(base, "t5a");
    chk("t5a_done_cycle", 32'(done_cyc - t0), 32'd1);
    chk("t5a_sp_out", 32'(done_sp), 32'h1234);
    check_logs("t5a");

    // 5b: start while busy is ignored
    clear_logs();
    exp_bus(1'b1, 32'h102FE, 16'hA000);
    exp_reg(4'd4, 16'h02FE);
    launch(16'h0001, 16'h0000, 16'h0300, 16'h1000, 2, t0, base);
    push_mask = 16'h00FF; pop_mask = 16'h00FF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(base, "t5b");
    chk("t5b_done_cycle", 32'(done_cyc - t0), 32'd4);
    repeat (6) @(negedge clk);
    #3;
    chk("t5b_single_done", 32'(done_cnt - base), 32'd1);
    chk("t5b_idle", 32'(busy), 32'd0);
    chk("t5b_sp_hold", 32'(sp_out), 32'h02FE);
    check_logs("t5b");

    // SP wrap on push from 0x0000
    clear_logs();
`ifdef STACK_WRAP_FAULT_EN
    launch(16'h0001, 16'h0000, 16'h0000, 16'h2000, 0, t0, base);
    wait_done(base, "wrap");
    chk("wrap_done_cycle", 32'(done_cyc - t0), 32'd1);
    chk("wrap_fault", 32'(done_wf), 32'd1);
    chk("wrap_sp_out", 32'(done_sp), 32'h0000);
`else
    exp_bus(1'b1, 32'h2FFFE, 16'hA000);
    exp_reg(4'd4, 16'hFFFE);
    launch(16'h0001, 16'h0000, 16'h0000, 16'h2000, 0, t0, base);
    wait_done(base, "wrap");
    chk("wrap_done_cycle", 32'(done_cyc - t0), 32'd2);
    chk("wrap_sp_out", 32'(done_sp), 32'hFFFE);
`endif
    check_logs("wrap");

    // 6: reset mid-sequence with a request outstanding, then a late ack
    clear_logs();
    launch(16'h0003, 16'h0000, 16'h0100, 16'h2000, 5, t0, base);
    @(negedge clk);
    #1;
    chk("t6_req_before_reset", 32'(mem_req), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    force_ack = 1'b1;
    #1;
    check_reset_state("t6");
    repeat (3) @(negedge clk);
    force_ack = 1'b0;
    #3;
    chk("t6_no_done", 32'(done_cnt - base), 32'd0);
    chk("t6_idle", 32'(busy), 32'd0);
    chk("t6_no_req", 32'(mem_req), 32'd0);
    check_logs("t6");

    chk("hold_stable_total", 32'(stab_err), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
